clock_ctrl: RTL and testbench

User-facing sequencer for the `clock` timekeeping core. It turns debounced single-cycle button pulses into the core's `start`, `set_alarm` and `set_hours`/`set_mins`/`set_secs` control sequence, and it supplies the value buses. It also owns the alarm enable, snooze gating of the buzzer, and an edit-inactivity timeout. It sits between the button front-end and `clock`.

---
 rtl/clock_pkg.sv | 46 ++++
 rtl/sec_tick_gen.sv | 40 ++++
 rtl/clock_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_clock_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants, state/target encodings and wrap arithmetic for the clock controller.
package clock_pkg;

  localparam int HW = 5;
  localparam int MW = 6;

  localparam logic [HW-1:0] HOURS_MAX = 5'd23;
  localparam logic [MW-1:0] MINS_MAX  = 6'd59;
  localparam logic [MW-1:0] SECS_MAX  = 6'd59;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_H    = 2'd1;
  localparam logic [1:0] FIELD_M    = 2'd2;
  localparam logic [1:0] FIELD_S    = 2'd3;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_EDIT_H   = 3'd1,
    ST_EDIT_M   = 3'd2,
    ST_EDIT_S   = 3'd3,
    ST_COMMIT_H = 3'd4,
    ST_COMMIT_M = 3'd5,
    ST_COMMIT_S = 3'd6
  } ctrl_state_t;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } edit_target_t;

  // One step up or down inside 0..max_v, wrapping at both ends.
  function automatic logic [MW-1:0] step_wrap(input logic [MW-1:0] v,
                                               input logic [MW-1:0] max_v,
                                               input logic          up);
    logic [MW-1:0] r;
    if (up) begin
      if (v >= max_v) r = 6'd0;
      else            r = v + 6'd1;
    end else begin
      if (v == 6'd0)  r = max_v;
      else            r = v - 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICKS_PER_SEC clocks.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count and tick.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Prescaler registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/clock_ctrl.sv
// Button-driven edit/commit sequencer for the clock core, with alarm arming,
// snooze gating and an edit-inactivity timeout.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC  = 100_000_000,
  parameter int EDIT_TIMEOUT_S = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_time,
  input  logic          btn_alarm,
  input  logic          btn_next,
  input  logic          btn_inc,
  input  logic          btn_dec,
  input  logic          btn_alarm_en,
  input  logic          btn_snooze,
  input  logic [HW-1:0] cur_hours,
  input  logic [MW-1:0] cur_mins,
  input  logic [MW-1:0] cur_secs,
  input  logic          buzzer_in,
  output logic          start,
  output logic          set_alarm,
  output logic          set_hours,
  output logic          set_mins,
  output logic          set_secs,
  output logic [HW-1:0] val_hours,
  output logic [MW-1:0] val_mins,
  output logic [MW-1:0] val_secs,
  output logic [1:0]    field,
  output logic          alarm_en,
  output logic          buzzer
);

  localparam int TW = (EDIT_TIMEOUT_S > 0) ? $clog2(EDIT_TIMEOUT_S + 1) : 1;
  localparam logic [TW-1:0] TO_LIMIT = TW'(EDIT_TIMEOUT_S);

  ctrl_state_t   state_q, state_d;
  edit_target_t  target_q, target_d;
  logic [HW-1:0] val_h_q, val_h_d, sh_h_q, sh_h_d;
  logic [MW-1:0] val_m_q, val_m_d, sh_m_q, sh_m_d;
  logic [MW-1:0] val_s_q, val_s_d, sh_s_q, sh_s_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          start_q, start_d, set_alarm_q, set_alarm_d;
  logic          set_h_q, set_h_d, set_m_q, set_m_d, set_s_q, set_s_d;
  logic [1:0]    field_q, field_d;
  logic          alarm_en_q, alarm_en_d, snoozed_q, snoozed_d, buzzer_q, buzzer_d;
  logic          tick, any_btn_s;
  logic [MW-1:0] step_h_s, step_m_s, step_s_s;

  sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign any_btn_s = btn_time | btn_alarm | btn_next | btn_inc | btn_dec |
                     btn_alarm_en | btn_snooze;

  // Sequencer: state, edit target, edit values, alarm shadow and timeout count.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    val_h_d  = val_h_q;
    val_m_d  = val_m_q;
    val_s_d  = val_s_q;
    sh_h_d   = sh_h_q;
    sh_m_d   = sh_m_q;
    sh_s_d   = sh_s_q;
    to_cnt_d = to_cnt_q;
    step_h_s = step_wrap(MW'(val_h_q), MW'(HOURS_MAX), btn_inc);
    step_m_s = step_wrap(val_m_q, MINS_MAX, btn_inc);
    step_s_s = step_wrap(val_s_q, SECS_MAX, btn_inc);
    case (state_q)
      ST_RUN: begin
        to_cnt_d = '0;
        if (btn_time) begin
          target_d = TGT_TIME;
          val_h_d  = cur_hours;
          val_m_d  = cur_mins;
          val_s_d  = cur_secs;
          state_d  = ST_EDIT_H;
        end else if (btn_alarm) begin
          target_d = TGT_ALARM;
          val_h_d  = sh_h_q;
          val_m_d  = sh_m_q;
          val_s_d  = sh_s_q;
          state_d  = ST_EDIT_H;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        // Leaves on the first tick after EDIT_TIMEOUT_S whole idle seconds.
        if (tick && (to_cnt_q == TO_LIMIT)) begin
          state_d  = ST_RUN;
          to_cnt_d = '0;
        end else begin
          if (any_btn_s)  to_cnt_d = '0;
          else if (tick)  to_cnt_d = to_cnt_q + TW'(1);
          else            to_cnt_d = to_cnt_q;
          if (btn_next) begin
            case (state_q)
              ST_EDIT_H: state_d = ST_EDIT_M;
              ST_EDIT_M: state_d = ST_EDIT_S;
              default:   state_d = ST_COMMIT_H;
            endcase
          end else if (btn_inc ^ btn_dec) begin
            case (state_q)
              ST_EDIT_H: val_h_d = step_h_s[HW-1:0];
              ST_EDIT_M: val_m_d = step_m_s;
              default:   val_s_d = step_s_s;
            endcase
          end else begin
            state_d = state_q;
          end
        end
      end
      ST_COMMIT_H: state_d = ST_COMMIT_M;
      ST_COMMIT_M: state_d = ST_COMMIT_S;
      ST_COMMIT_S: begin
        state_d = ST_RUN;
        if (target_q == TGT_ALARM) begin
          sh_h_d = val_h_q;
          sh_m_d = val_m_q;
          sh_s_d = val_s_q;
        end else begin
          sh_h_d = sh_h_q;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output decode from the next state, plus alarm arming and snooze gating.
  always_comb begin
    start_d     = ~((state_d != ST_RUN) && (target_d == TGT_TIME));
    set_alarm_d = (state_d inside {ST_COMMIT_H, ST_COMMIT_M, ST_COMMIT_S}) &&
                  (target_d == TGT_ALARM);
    set_h_d     = (state_d == ST_COMMIT_H);
    set_m_d     = (state_d == ST_COMMIT_M);
    set_s_d     = (state_d == ST_COMMIT_S);
    case (state_d)
      ST_EDIT_H: field_d = FIELD_H;
      ST_EDIT_M: field_d = FIELD_M;
      ST_EDIT_S: field_d = FIELD_S;
      default:   field_d = FIELD_NONE;
    endcase
    alarm_en_d = alarm_en_q ^ btn_alarm_en;
    if (btn_alarm_en || !buzzer_in) snoozed_d = 1'b0;
    else if (btn_snooze)            snoozed_d = 1'b1;
    else                            snoozed_d = snoozed_q;
    buzzer_d = buzzer_in & alarm_en_d & ~snoozed_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      target_q    <= TGT_TIME;
      val_h_q     <= '0;
      val_m_q     <= '0;
      val_s_q     <= '0;
      sh_h_q      <= '0;
      sh_m_q      <= '0;
      sh_s_q      <= '0;
      to_cnt_q    <= '0;
      start_q     <= 1'b0;
      set_alarm_q <= 1'b0;
      set_h_q     <= 1'b0;
      set_m_q     <= 1'b0;
      set_s_q     <= 1'b0;
      field_q     <= FIELD_NONE;
      alarm_en_q  <= 1'b0;
      snoozed_q   <= 1'b0;
      buzzer_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      val_h_q     <= val_h_d;
      val_m_q     <= val_m_d;
      val_s_q     <= val_s_d;
      sh_h_q      <= sh_h_d;
      sh_m_q      <= sh_m_d;
      sh_s_q      <= sh_s_d;
      to_cnt_q    <= to_cnt_d;
      start_q     <= start_d;
      set_alarm_q <= set_alarm_d;
      set_h_q     <= set_h_d;
      set_m_q     <= set_m_d;
      set_s_q     <= set_s_d;
      field_q     <= field_d;
      alarm_en_q  <= alarm_en_d;
      snoozed_q   <= snoozed_d;
      buzzer_q    <= buzzer_d;
    end
  end

  assign start     = start_q;
  assign set_alarm = set_alarm_q;
  assign set_hours = set_h_q;
  assign set_mins  = set_m_q;
  assign set_secs  = set_s_q;
  assign val_hours = val_h_q;
  assign val_mins  = val_m_q;
  assign val_secs  = val_s_q;
  assign field     = field_q;
  assign alarm_en  = alarm_en_q;
  assign buzzer    = buzzer_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Randomised scoreboard bench for clock_ctrl: a modular-arithmetic model predicts
// edit values and commit strobes; a monitor pops expected strobes as they appear.
module tb_clock_ctrl;

  localparam logic [6:0] B_TIME  = 7'd1;
  localparam logic [6:0] B_ALARM = 7'd2;
  localparam logic [6:0] B_NEXT  = 7'd4;
  localparam logic [6:0] B_INC   = 7'd8;
  localparam logic [6:0] B_DEC   = 7'd16;
  localparam logic [6:0] B_AEN   = 7'd32;
  localparam logic [6:0] B_SNZ   = 7'd64;

  logic       clk, reset, buzzer_in;
  logic [6:0] btn_v;
  logic [4:0] cur_h;
  logic [5:0] cur_m, cur_s;
  logic       start, set_alarm, set_hours, set_mins, set_secs, alarm_en, buzzer;
  logic [4:0] val_hours;
  logic [5:0] val_mins, val_secs;
  logic [1:0] field;

  clock_ctrl #(.TICKS_PER_SEC(4), .EDIT_TIMEOUT_S(3)) dut (
    .clk(clk), .reset(reset),
    .btn_time(btn_v[0]), .btn_alarm(btn_v[1]), .btn_next(btn_v[2]),
    .btn_inc(btn_v[3]), .btn_dec(btn_v[4]), .btn_alarm_en(btn_v[5]),
    .btn_snooze(btn_v[6]),
    .cur_hours(cur_h), .cur_mins(cur_m), .cur_secs(cur_s), .buzzer_in(buzzer_in),
    .start(start), .set_alarm(set_alarm), .set_hours(set_hours),
    .set_mins(set_mins), .set_secs(set_secs), .val_hours(val_hours),
    .val_mins(val_mins), .val_secs(val_secs), .field(field),
    .alarm_en(alarm_en), .buzzer(buzzer)
  );

  typedef struct {
    logic [2:0] kind;
    bit         alarm;
    bit         run;
    int         h, m, s;
  } strobe_t;

  strobe_t sb_q[$];
  strobe_t mon_e;
  int      tests = 0;
  int      fails = 0;

  // Reference model state.
  int ed_v[3];
  int sh_v[3];
  int maxv[3] = '{23, 59, 59};
  int fld;
  bit tgt_alarm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (set_hours || set_mins || set_secs) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got hms=%b, expected none (t=%0t)",
                 {set_hours, set_mins, set_secs}, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("strobe_hms", int'({set_hours, set_mins, set_secs}), int'(mon_e.kind));
        chk("strobe_set_alarm", int'(set_alarm), int'(mon_e.alarm));
        chk("strobe_start", int'(start), int'(mon_e.run));
        chk("strobe_val", val_hours * 10000 + val_mins * 100 + val_secs,
            mon_e.h * 10000 + mon_e.m * 100 + mon_e.s);
      end
    end
  end

  task automatic apply(input logic [6:0] b);
    btn_v = b;
    @(negedge clk);
    btn_v = '0;
  endtask

  task automatic chk_vals(input string tag);
    chk({tag, "_val_hours"}, int'(val_hours), ed_v[0]);
    chk({tag, "_val_mins"},  int'(val_mins),  ed_v[1]);
    chk({tag, "_val_secs"},  int'(val_secs),  ed_v[2]);
  endtask

  task automatic push_strobes(input int n);
    logic [2:0] k;
    k = 3'b100;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{kind: k, alarm: tgt_alarm, run: tgt_alarm,
                       h: ed_v[0], m: ed_v[1], s: ed_v[2]});
      k = k >> 1;
    end
  endtask

  // kind: 0 time, 1 alarm, 2 both (time wins)
  task automatic enter(input int kind);
    tgt_alarm = (kind == 1);
    apply(kind == 0 ? B_TIME : (kind == 1 ? B_ALARM : (B_TIME | B_ALARM)));
    fld = 0;
    if (tgt_alarm) ed_v = sh_v;
    else begin
      ed_v[0] = int'(cur_h); ed_v[1] = int'(cur_m); ed_v[2] = int'(cur_s);
    end
    chk_vals("enter");
    chk("enter_field", int'(field), 1);
    chk("enter_start", int'(start), tgt_alarm ? 1 : 0);
  endtask

  // kind: 0 inc, 1 dec, 2 inc+dec, 3 next, 4 next+inc
  task automatic op(input int kind);
    logic [6:0] b;
    int         md;
    case (kind)
      0:       b = B_INC;
      1:       b = B_DEC;
      2:       b = B_INC | B_DEC;
      3:       b = B_NEXT;
      default: b = B_NEXT | B_INC;
    endcase
    if (kind >= 3 && fld == 2) push_strobes(3);
    apply(b);
    md = maxv[fld] + 1;
    if (kind == 0) ed_v[fld] = (ed_v[fld] + 1) % md;
    if (kind == 1) ed_v[fld] = (ed_v[fld] + md - 1) % md;
    if (kind < 3 || fld < 2) begin
      if (kind >= 3) fld++;
      chk_vals("edit");
      chk("edit_field", int'(field), fld + 1);
      chk("edit_start", int'(start), tgt_alarm ? 1 : 0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        btn_v = 7'($urandom_range(0, 31));
        @(negedge clk);
      end
      btn_v = '0;
      chk("commit_start", int'(start), 1);
      chk("commit_field", int'(field), 0);
      chk("commit_set_alarm", int'(set_alarm), 0);
      chk_vals("commit");
      if (tgt_alarm) sh_v = ed_v;
      #1;
      chk("commit_sb_empty", sb_q.size(), 0);
    end
  endtask

  task automatic timeout_check(input int kind);
    int k;
    enter(kind);
    k = 0;
    while (k < 40 && field != 2'd0) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k < 12 || k > 16) begin
      fails++;
      $display("FAIL timeout_window: returned after %0d cycles, expected 12..16", k);
    end
    chk("timeout_start", int'(start), 1);
    chk("timeout_sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; btn_v = '0; buzzer_in = 1'b0;
    cur_h = 5'd0; cur_m = 6'd0; cur_s = 6'd0;
    sh_v = '{0, 0, 0};
    repeat (2) @(negedge clk);
    chk("rst_start", int'(start), 0);
    chk("rst_field", int'(field), 0);
    chk("rst_vals", val_hours + val_mins + val_secs, 0);
    chk("rst_set_alarm", int'(set_alarm), 0);
    chk("rst_alarm_en", int'(alarm_en), 0);
    chk("rst_buzzer", int'(buzzer), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_start", int'(start), 1);

    // Time edit 10:20:30, hours +14 wraps to 00
    cur_h = 5'd10; cur_m = 6'd20; cur_s = 6'd30;
    enter(0);
    repeat (14) op(0);
    chk("h_wrap_to_0", int'(val_hours), 0);
    repeat (3) op(3);

    // Minute wrap both ways, inc+dec cancels
    cur_h = 5'd5; cur_m = 6'd0; cur_s = 6'd7;
    enter(0);
    op(3); op(1);
    chk("m_dec_wrap", int'(val_mins), 59);
    op(0); op(2);
    chk("m_inc_dec_same", int'(val_mins), 0);
    op(3); op(3);

    // Alarm edit to 00:03:02, then reload from the shadow
    enter(1);
    op(3); repeat (3) op(0);
    op(3); repeat (2) op(0);
    op(3);
    enter(1);
    chk("alarm_reload", val_hours * 10000 + val_mins * 100 + val_secs, 302);
    repeat (3) op(3);

    // Randomised edits
    for (int r = 0; r < 8; r++) begin
      cur_h = 5'($urandom_range(0, 23));
      cur_m = 6'($urandom_range(0, 59));
      cur_s = 6'($urandom_range(0, 59));
      enter($urandom_range(0, 2));
      for (int f = 0; f < 3; f++) begin
        for (int n = $urandom_range(0, 8); n > 0; n--) op($urandom_range(0, 2));
        op($urandom_range(3, 4));
      end
    end

    timeout_check(0);
    timeout_check(1);

    // Buzzer gating
    buzzer_in = 1'b0;
    apply(B_AEN);
    chk("aen_on", int'(alarm_en), 1);
    chk("buz_idle", int'(buzzer), 0);
    buzzer_in = 1'b1; @(negedge clk);
    chk("buz_on", int'(buzzer), 1);
    apply(B_SNZ);
    chk("buz_snoozed", int'(buzzer), 0);
    repeat (3) @(negedge clk);
    chk("buz_snooze_holds", int'(buzzer), 0);
    buzzer_in = 1'b0; @(negedge clk);
    chk("buz_fall", int'(buzzer), 0);
    buzzer_in = 1'b1; @(negedge clk);
    chk("buz_rearm", int'(buzzer), 1);
    apply(B_SNZ);
    chk("buz_snoozed2", int'(buzzer), 0);
    apply(B_AEN);
    chk("aen_off", int'(alarm_en), 0);
    chk("buz_disabled", int'(buzzer), 0);
    apply(B_AEN);
    chk("aen_on2", int'(alarm_en), 1);
    chk("buz_toggle_clears_snooze", int'(buzzer), 1);
    buzzer_in = 1'b0;
    apply(B_SNZ);
    chk("buz_low", int'(buzzer), 0);
    buzzer_in = 1'b1; @(negedge clk);
    chk("buz_snooze_when_low_ignored", int'(buzzer), 1);
    buzzer_in = 1'b0;
    apply(B_AEN);

    // Reset during COMMIT_M
    cur_h = 5'd7; cur_m = 6'd8; cur_s = 6'd9;
    enter(0);
    op(3); op(3);
    push_strobes(2);
    apply(B_NEXT);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_start", int'(start), 0);
    chk("midrst_field", int'(field), 0);
    reset = 1'b0;
    sh_v = '{0, 0, 0};
    @(negedge clk);
    chk("midrst_post_start", int'(start), 1);
    chk("midrst_post_field", int'(field), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_sb_empty", sb_q.size(), 0);

    enter(1);
    repeat (3) op(3);

    repeat (4) @(negedge clk);
    #1;
    chk("final_sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
